pit_intc: RTL and testbench
===========================

Name: pit_intc

Overview:
- Bus-attached interrupt controller that sits directly downstream of the PIT.
- Consumes the PIT's IP_Interupt line plus up to NUM_SRC-1 other peripheral interrupt lines, latches rising edges into a pending register, and masks them with an enable register.
- Drives one registered interrupt line to the processor.
- Slave-side register access uses the same Bus2IP/IP2Bus IPIF signalling as the PIT.

Parameters:
- NUM_SRC, 4, number of interrupt sources (1..32); source 0 is the PIT.
- C_SLV_DWIDTH, 32, bus data width.
- NUM_REGS, 4, number of addressable registers (RdCE/WrCE width).

Ports:
- Bus2IP_Clk  input  1  system clock; all logic is on its rising edge.
- Bus2IP_Reset  input  1  asynchronous, active-high reset.
- Intr_In  input  NUM_SRC  interrupt request lines; bit 0 is the PIT's IP_Interupt.
- Bus2IP_Data  input  C_SLV_DWIDTH  write data.
- Bus2IP_BE  input  C_SLV_DWIDTH/8  byte enables for writes.
- Bus2IP_RdCE  input  NUM_REGS  one-hot read select; bit 3 = reg0 ... bit 0 = reg3.
- Bus2IP_WrCE  input  NUM_REGS  one-hot write select, same ordering.
- IP2Bus_Data  output  C_SLV_DWIDTH  read data.
- IP2Bus_RdAck  output  1  read acknowledge.
- IP2Bus_WrAck  output  1  write acknowledge.
- IP2Bus_Error  output  1  always 0.
- Irq  output  1  interrupt to the processor.

Behaviour:
- Reset is asynchronous and active-high: one clock (Bus2IP_Clk), and Bus2IP_Reset asynchronously clears every state element.
- Values held in reset: ISR=0, IER=0, MER=0, the Intr_In delay register=0, Irq=0.
- Combinational outputs while reset is asserted: IP2Bus_Data=0 when no RdCE is set; RdAck/WrAck follow CE.
- Registers:
  - reg0 ISR: pending bits. Read returns pending; write 1 clears a bit, write 0 has no effect.
  - reg1 IER: enable mask, read/write.
  - reg2 IPR: ISR & IER, read-only; writes are acknowledged and ignored.
  - reg3 MER: bit0 ME (master enable), bit1 HIE (hardware interrupt enable). Other bits read 0.
- Edge capture:
  - Intr_In is registered once (Intr_d).
  - Rising edge = Intr_In & ~Intr_d; it sets ISR[i] on the next clock edge, independent of IER.
  - A level held high sets ISR exactly once.
- Set/clear collision: in the same cycle as a W1C of the same bit, the set wins and the bit stays 1.
- Irq timing: registered; Irq <= ME & HIE & |(ISR & IER). Latency is 2 clocks from the source rising edge to Irq high.
- Irq deassertion: falls 1 clock after the clearing write, or 1 clock after the IER or MER bit is cleared.
- Writes:
  - Take effect on the rising edge where WrCE is nonzero.
  - Honour BE per byte; bytes with BE=0 are unchanged. ISR W1C bits are masked by BE.
  - Bits at or above NUM_SRC are ignored and read 0.
- Acks:
  - IP2Bus_WrAck = |Bus2IP_WrCE and IP2Bus_RdAck = |Bus2IP_RdCE, both combinational, so access is single-cycle.
  - Holding a CE for N cycles repeats the access N times; this is harmless for every register.
- Read data: combinational mux on RdCE, 0 when no RdCE is set. A non-one-hot CE (more than one bit set) reads 0 and writes nothing, but is still acknowledged.
- Mid-operation reset: pending interrupts are discarded. An Intr_In that is already high when reset releases does not produce an edge, because Intr_d loads the high value after 1 clock; the first sample counts as the reference, not as an edge.

Optional Feature:
- Macro: PIT_INTC_VECTOR_EN.
- Defined: reg2 reads return the lowest index i with ISR[i]&IER[i], zero-extended in bits [7:0]; it returns 32'hFFFF_FFFF when none is pending. The IPR view is then unavailable.
- Undefined: reg2 reads the IPR as described above.
- Register widths, timing and the Irq path are identical in both builds.

Test Plan:
- Reset, then read all four registers -> each reads 0; Irq=0; RdAck high only while RdCE is set.
- Write IER=0x1 and MER=0x3, then pulse Intr_In[0] high for 1 cycle -> ISR=0x1 after 1 clock, Irq=1 two clocks after the edge. Write 0x1 to ISR -> Irq=0 one clock later; ISR reads 0.
- Hold Intr_In[1] high for 50 cycles with IER=0x0 -> ISR=0x2 (a single latch), Irq stays 0. Then write IER=0x2 -> Irq=1 one clock later.
- Issue a W1C of ISR bit 0 in the same cycle as a new Intr_In[0] rising edge -> ISR[0] stays 1 and Irq stays 1.
- MER=0x1 (HIE=0) with IER=0xF and Intr_In=0xF edges -> ISR=0xF, Irq=0. Write MER=0x3 -> Irq=1. Write BE=4'b0000 to IER -> IER unchanged.
- With PIT_INTC_VECTOR_EN, ISR=0xC and IER=0x8 -> reg2 reads 3. Clear ISR -> reg2 reads 0xFFFFFFFF. Without the macro, the same state reads 0x8.

Source files
------------

// File: rtl/pit_intc.sv
// pit_intc: interrupt controller sitting behind the PIT.
// Latches rising edges of Intr_In into ISR, masks them with IER and gates the result with
// MER (ME and HIE) to drive a registered Irq. Register access uses IPIF CE-style signalling.
// Optional build macro PIT_INTC_VECTOR_EN: reg2 returns the lowest pending+enabled source
// index (0xFFFF_FFFF when none) instead of the IPR view.
module pit_intc #(
   parameter int unsigned NUM_SRC      = 4,
   parameter int unsigned C_SLV_DWIDTH = 32,
   parameter int unsigned NUM_REGS     = 4
) (
   input  logic                        Bus2IP_Clk,
   input  logic                        Bus2IP_Reset,
   input  logic [NUM_SRC-1:0]          Intr_In,
   input  logic [C_SLV_DWIDTH-1:0]     Bus2IP_Data,
   input  logic [C_SLV_DWIDTH/8-1:0]   Bus2IP_BE,
   input  logic [NUM_REGS-1:0]         Bus2IP_RdCE,
   input  logic [NUM_REGS-1:0]         Bus2IP_WrCE,
   output logic [C_SLV_DWIDTH-1:0]     IP2Bus_Data,
   output logic                        IP2Bus_RdAck,
   output logic                        IP2Bus_WrAck,
   output logic                        IP2Bus_Error,
   output logic                        Irq
);

   // CE bit positions: the highest CE bit selects reg0.
   localparam int unsigned CE_ISR = NUM_REGS - 1;
   localparam int unsigned CE_IER = NUM_REGS - 2;
   localparam int unsigned CE_IPR = NUM_REGS - 3;
   localparam int unsigned CE_MER = NUM_REGS - 4;

   logic [NUM_SRC-1:0]      isr_q, isr_d;
   logic [NUM_SRC-1:0]      ier_q, ier_d;
   logic [1:0]              mer_q, mer_d;
   logic [NUM_SRC-1:0]      intr_d_q;
   // Low for the first clock after reset so the first Intr_In sample is only a reference.
   logic                    armed_q;
   logic                    irq_q, irq_d;

   logic [NUM_SRC-1:0]      be_mask;
   logic [NUM_SRC-1:0]      wr_data;
   logic [NUM_SRC-1:0]      rise;
   logic [NUM_SRC-1:0]      ipr;
   logic                    wr_ok;
   logic                    wr_isr, wr_ier, wr_mer;
   logic [C_SLV_DWIDTH-1:0] reg2_data;
   logic [C_SLV_DWIDTH-1:0] rd_data;
   logic                    unused_bus;

   // Bits beyond NUM_SRC (and byte lanes above them) carry nothing.
   assign unused_bus = ^{Bus2IP_Data, Bus2IP_BE};

   assign ipr     = isr_q & ier_q;
   assign wr_data = Bus2IP_Data[NUM_SRC-1:0];
   assign rise    = armed_q ? (Intr_In & ~intr_d_q) : '0;

   // Expand byte enables to a per-bit write mask.
   always_comb begin
      be_mask = '0;
      for (int b = 0; b < int'(NUM_SRC); b++) begin
         be_mask[b] = Bus2IP_BE[b/8];
      end
   end

   // Decode writes; a non-one-hot WrCE is acknowledged but writes nothing.
   always_comb begin
      wr_ok  = $onehot(Bus2IP_WrCE);
      wr_isr = wr_ok & Bus2IP_WrCE[CE_ISR];
      wr_ier = wr_ok & Bus2IP_WrCE[CE_IER];
      wr_mer = wr_ok & Bus2IP_WrCE[CE_MER];
   end

   // Next-state: W1C is applied before new edges are OR-ed in, so a same-cycle set wins.
   always_comb begin
      isr_d = isr_q;
      if (wr_isr) begin
         isr_d = isr_q & ~(wr_data & be_mask);
      end
      isr_d = isr_d | rise;

      ier_d = ier_q;
      if (wr_ier) begin
         ier_d = (ier_q & ~be_mask) | (wr_data & be_mask);
      end

      mer_d = mer_q;
      if (wr_mer && Bus2IP_BE[0]) begin
         mer_d = Bus2IP_Data[1:0];
      end

      irq_d = mer_q[0] & mer_q[1] & (|ipr);
   end

   // All state, cleared asynchronously by reset.
   always_ff @(posedge Bus2IP_Clk or posedge Bus2IP_Reset) begin
      if (Bus2IP_Reset) begin
         isr_q    <= '0;
         ier_q    <= '0;
         mer_q    <= '0;
         intr_d_q <= '0;
         armed_q  <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         isr_q    <= isr_d;
         ier_q    <= ier_d;
         mer_q    <= mer_d;
         intr_d_q <= Intr_In;
         armed_q  <= 1'b1;
         irq_q    <= irq_d;
      end
   end

`ifdef PIT_INTC_VECTOR_EN
   // Lowest-index pending and enabled source; all ones when nothing is pending.
   always_comb begin
      reg2_data = '1;
      for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
         if (ipr[i]) begin
            reg2_data = {{(C_SLV_DWIDTH-8){1'b0}}, 8'(i)};
         end
      end
   end
`else
   // Plain IPR view.
   always_comb begin
      reg2_data = C_SLV_DWIDTH'(ipr);
   end
`endif

   // Read mux; zero unless exactly one RdCE bit is set.
   always_comb begin
      rd_data = '0;
      if ($onehot(Bus2IP_RdCE)) begin
         unique case (1'b1)
            Bus2IP_RdCE[CE_ISR]: rd_data = C_SLV_DWIDTH'(isr_q);
            Bus2IP_RdCE[CE_IER]: rd_data = C_SLV_DWIDTH'(ier_q);
            Bus2IP_RdCE[CE_IPR]: rd_data = reg2_data;
            Bus2IP_RdCE[CE_MER]: rd_data = C_SLV_DWIDTH'(mer_q);
            default:             rd_data = '0;
         endcase
      end
   end

   assign IP2Bus_Data  = rd_data;
   assign IP2Bus_RdAck = |Bus2IP_RdCE;
   assign IP2Bus_WrAck = |Bus2IP_WrCE;
   assign IP2Bus_Error = 1'b0;
   assign Irq          = irq_q;

endmodule

// File: tb/tb_pit_intc.sv
// tb_pit_intc: directed vector table, hand-written corner sequences and a randomized run
// checked against a behavioural model of pit_intc.
module tb_pit_intc;

   localparam int unsigned NSRC = 4;
   localparam int unsigned DW   = 32;
   localparam int unsigned NR   = 4;

   localparam logic [3:0] R0 = 4'b1000;
   localparam logic [3:0] R1 = 4'b0100;
   localparam logic [3:0] R2 = 4'b0010;
   localparam logic [3:0] R3 = 4'b0001;

`ifdef PIT_INTC_VECTOR_EN
   localparam bit VEC = 1'b1;
`else
   localparam bit VEC = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst;
   logic [NSRC-1:0] Intr_In;
   logic [DW-1:0]   Bus2IP_Data;
   logic [DW/8-1:0] Bus2IP_BE;
   logic [NR-1:0]   Bus2IP_RdCE;
   logic [NR-1:0]   Bus2IP_WrCE;
   logic [DW-1:0]   IP2Bus_Data;
   logic            IP2Bus_RdAck;
   logic            IP2Bus_WrAck;
   logic            IP2Bus_Error;
   logic            Irq;

   always #5 clk = ~clk;

   pit_intc #(
      .NUM_SRC     (NSRC),
      .C_SLV_DWIDTH(DW),
      .NUM_REGS    (NR)
   ) dut (
      .Bus2IP_Clk  (clk),
      .Bus2IP_Reset(rst),
      .Intr_In     (Intr_In),
      .Bus2IP_Data (Bus2IP_Data),
      .Bus2IP_BE   (Bus2IP_BE),
      .Bus2IP_RdCE (Bus2IP_RdCE),
      .Bus2IP_WrCE (Bus2IP_WrCE),
      .IP2Bus_Data (IP2Bus_Data),
      .IP2Bus_RdAck(IP2Bus_RdAck),
      .IP2Bus_WrAck(IP2Bus_WrAck),
      .IP2Bus_Error(IP2Bus_Error),
      .Irq         (Irq)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // One bus cycle: drive after the edge, sample mid-cycle, then let the next edge happen.
   task automatic step(input logic [3:0] intr, input logic [3:0] rdce, input logic [3:0] wrce,
                       input logic [31:0] data, input logic [3:0] be,
                       input logic [31:0] exp_rd, input logic exp_irq, input string name);
      Intr_In     = intr;
      Bus2IP_RdCE = rdce;
      Bus2IP_WrCE = wrce;
      Bus2IP_Data = data;
      Bus2IP_BE   = be;
      #4;
      check({name, " rd"}, IP2Bus_Data, exp_rd);
      check({name, " irq"}, 32'(Irq), 32'(exp_irq));
      check({name, " rdack"}, 32'(IP2Bus_RdAck), 32'(|rdce));
      check({name, " wrack"}, 32'(IP2Bus_WrAck), 32'(|wrce));
      @(posedge clk);
      #1;
   endtask

   // Assert reset asynchronously, check the held values, release just after an edge.
   task automatic do_reset(input logic [3:0] intr);
      Intr_In     = intr;
      Bus2IP_WrCE = '0;
      Bus2IP_RdCE = '0;
      Bus2IP_Data = '0;
      Bus2IP_BE   = '0;
      rst         = 1'b1;
      #2;
      check("reset irq", 32'(Irq), 32'h0);
      check("reset rd idle", IP2Bus_Data, 32'h0);
      check("reset rdack idle", 32'(IP2Bus_RdAck), 32'h0);
      Bus2IP_RdCE = R0;
      #1;
      check("reset rd isr", IP2Bus_Data, 32'h0);
      check("reset rdack", 32'(IP2Bus_RdAck), 32'h1);
      check("reset error", 32'(IP2Bus_Error), 32'h0);
      Bus2IP_RdCE = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // ---------------- behavioural model ----------------
   logic [31:0] m_isr, m_ier, m_mer;
   logic [3:0]  m_prev;
   bit          m_armed, m_irq;

   function automatic void m_reset();
      m_isr = 0; m_ier = 0; m_mer = 0; m_prev = 0; m_armed = 0; m_irq = 0;
   endfunction

   function automatic logic [31:0] m_reg2();
      logic [31:0] p;
      p = m_isr & m_ier;
      if (VEC) begin
         for (int i = 0; i < int'(NSRC); i++) if (p[i]) return 32'(i);
         return 32'hFFFF_FFFF;
      end
      return p;
   endfunction

   function automatic logic [31:0] m_read(input logic [3:0] rdce);
      logic [31:0] v;
      v = 0;
      if ($countones(rdce) != 1) return 0;
      for (int k = 0; k < 4; k++) begin
         if (rdce[3-k]) begin
            case (k)
               0: v = m_isr;
               1: v = m_ier;
               2: v = m_reg2();
               default: v = m_mer;
            endcase
         end
      end
      return v;
   endfunction

   function automatic void m_clock(input logic [3:0] intr, input logic [3:0] wrce,
                                   input logic [31:0] data, input logic [3:0] be);
      bit nxt_irq;
      int sel;
      nxt_irq = (m_mer[1:0] == 2'b11) && ((m_isr & m_ier) != 0);
      sel = -1;
      if ($countones(wrce) == 1)
         for (int k = 0; k < 4; k++) if (wrce[3-k]) sel = k;
      for (int i = 0; i < int'(NSRC); i++) begin
         if (be[i/8]) begin
            if (sel == 0 && data[i]) m_isr[i] = 1'b0;
            if (sel == 1) m_ier[i] = data[i];
         end
         if (m_armed && intr[i] && !m_prev[i]) m_isr[i] = 1'b1;
      end
      if (sel == 3 && be[0]) m_mer = {30'b0, data[1:0]};
      m_prev  = intr;
      m_armed = 1'b1;
      m_irq   = nxt_irq;
   endfunction

   typedef struct {
      logic [3:0]  intr;
      logic [3:0]  rdce;
      logic [3:0]  wrce;
      logic [31:0] data;
      logic [3:0]  be;
      logic [31:0] exp_rd;
      logic        exp_irq;
   } vec_t;

   vec_t tbl[13];

   initial begin
      logic [31:0] vnone;
      logic [3:0]  cur, rdce, wrce, be;
      logic [31:0] data;
      int          op;

      vnone = VEC ? 32'hFFFF_FFFF : 32'h0;
      tbl[0]  = '{4'h0, R0, 4'h0, 32'h0, 4'hF, 32'h0, 1'b0};
      tbl[1]  = '{4'h0, R1, 4'h0, 32'h0, 4'hF, 32'h0, 1'b0};
      tbl[2]  = '{4'h0, R2, 4'h0, 32'h0, 4'hF, vnone, 1'b0};
      tbl[3]  = '{4'h0, R3, 4'h0, 32'h0, 4'hF, 32'h0, 1'b0};
      tbl[4]  = '{4'h0, 4'h0, 4'h0, 32'h0, 4'hF, 32'h0, 1'b0};
      tbl[5]  = '{4'h0, 4'h0, R1, 32'h1, 4'hF, 32'h0, 1'b0};
      tbl[6]  = '{4'h0, 4'h0, R3, 32'h3, 4'hF, 32'h0, 1'b0};
      tbl[7]  = '{4'h1, 4'h0, 4'h0, 32'h0, 4'hF, 32'h0, 1'b0};
      tbl[8]  = '{4'h0, R0, 4'h0, 32'h0, 4'hF, 32'h1, 1'b0};
      tbl[9]  = '{4'h0, R0, 4'h0, 32'h0, 4'hF, 32'h1, 1'b1};
      tbl[10] = '{4'h0, 4'h0, R0, 32'h1, 4'hF, 32'h0, 1'b1};
      tbl[11] = '{4'h0, R0, 4'h0, 32'h0, 4'hF, 32'h0, 1'b1};
      tbl[12] = '{4'h0, R0, 4'h0, 32'h0, 4'hF, 32'h0, 1'b0};

      do_reset(4'h0);
      for (int n = 0; n < 13; n++) begin
         step(tbl[n].intr, tbl[n].rdce, tbl[n].wrce, tbl[n].data, tbl[n].be,
              tbl[n].exp_rd, tbl[n].exp_irq, $sformatf("tbl%0d", n));
      end

      // Level held high latches once; enabling it later raises Irq one clock on.
      step(4'h0, 4'h0, R1, 32'h0, 4'hF, 32'h0, 1'b0, "ier off");
      for (int i = 0; i < 50; i++) begin
         step(4'h2, R0, 4'h0, 32'h0, 4'hF, (i == 0) ? 32'h0 : 32'h2, 1'b0, "hold level");
      end
      step(4'h2, 4'h0, R1, 32'h2, 4'hF, 32'h0, 1'b0, "ier on");
      step(4'h2, R2, 4'h0, 32'h0, 4'hF, VEC ? 32'h1 : 32'h2, 1'b0, "ipr level");
      step(4'h0, R0, 4'h0, 32'h0, 4'hF, 32'h2, 1'b1, "irq after ier");

      // Same-cycle W1C and new edge: the set wins.
      step(4'h0, 4'h0, R1, 32'h3, 4'hF, 32'h0, 1'b1, "ier 3");
      step(4'h1, 4'h0, 4'h0, 32'h0, 4'hF, 32'h0, 1'b1, "edge0");
      step(4'h0, R0, 4'h0, 32'h0, 4'hF, 32'h3, 1'b1, "isr 3");
      step(4'h1, 4'h0, R0, 32'h1, 4'hF, 32'h0, 1'b1, "collide");
      step(4'h0, R0, 4'h0, 32'h0, 4'hF, 32'h3, 1'b1, "collide isr");
      step(4'h0, 4'h0, R0, 32'hF, 4'hF, 32'h0, 1'b1, "clear all");
      step(4'h0, R0, 4'h0, 32'h0, 4'hF, 32'h0, 1'b1, "irq lag");
      step(4'h0, 4'h0, 4'h0, 32'h0, 4'hF, 32'h0, 1'b0, "irq fell");

      // HIE gating, byte enables, out-of-range bits, non-one-hot CE.
      step(4'h0, 4'h0, R3, 32'h1, 4'hF, 32'h0, 1'b0, "mer me");
      step(4'h0, 4'h0, R1, 32'hF, 4'hF, 32'h0, 1'b0, "ier F");
      step(4'hF, 4'h0, 4'h0, 32'h0, 4'hF, 32'h0, 1'b0, "edges F");
      step(4'h0, R0, 4'h0, 32'h0, 4'hF, 32'hF, 1'b0, "isr F hie0");
      step(4'h0, 4'h0, R3, 32'h3, 4'hF, 32'h0, 1'b0, "mer 3");
      step(4'h0, R3, 4'h0, 32'h0, 4'hF, 32'h3, 1'b0, "mer rd");
      step(4'h0, R1, 4'h0, 32'h0, 4'hF, 32'hF, 1'b1, "irq hie");
      step(4'h0, 4'h0, R1, 32'h0, 4'h0, 32'h0, 1'b1, "ier be0");
      step(4'h0, R1, 4'h0, 32'h0, 4'hF, 32'hF, 1'b1, "ier kept be0");
      step(4'h0, 4'h0, R1, 32'h0, 4'hE, 32'h0, 1'b1, "ier be upper");
      step(4'h0, R1, 4'h0, 32'h0, 4'hF, 32'hF, 1'b1, "ier kept be upper");
      step(4'h0, 4'h0, R1, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1, "ier all ones");
      step(4'h0, R1, 4'h0, 32'h0, 4'hF, 32'hF, 1'b1, "ier width");
      step(4'h0, 4'h0, 4'b0110, 32'h0, 4'hF, 32'h0, 1'b1, "wr multi ce");
      step(4'h0, R1, 4'h0, 32'h0, 4'hF, 32'hF, 1'b1, "ier kept multi");
      step(4'h0, 4'b1100, 4'h0, 32'h0, 4'hF, 32'h0, 1'b1, "rd multi ce");
      step(4'h0, 4'h0, R3, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1, "mer all ones");
      step(4'h0, R3, 4'h0, 32'h0, 4'hF, 32'h3, 1'b1, "mer width");

      // Vector / IPR view.
      step(4'h0, 4'h0, R0, 32'h3, 4'hF, 32'h0, 1'b1, "isr to C");
      step(4'h0, 4'h0, R1, 32'h8, 4'hF, 32'h0, 1'b1, "ier 8");
      step(4'h0, R2, 4'h0, 32'h0, 4'hF, VEC ? 32'h3 : 32'h8, 1'b1, "reg2 C&8");
      step(4'h0, 4'h0, R0, 32'hF, 4'hF, 32'h0, 1'b1, "isr clr");
      step(4'h0, R2, 4'h0, 32'h0, 4'hF, vnone, 1'b1, "reg2 none");
      step(4'h0, R2, 4'h0, 32'h0, 4'hF, vnone, 1'b0, "irq off");

      // Mid-operation reset with Intr_In held high: pending lost, no edge afterwards.
      step(4'h1, 4'h0, 4'h0, 32'h0, 4'hF, 32'h0, 1'b0, "pre-reset edge");
      do_reset(4'h1);
      step(4'h1, R0, 4'h0, 32'h0, 4'hF, 32'h0, 1'b0, "post reset 0");
      step(4'h1, R0, 4'h0, 32'h0, 4'hF, 32'h0, 1'b0, "post reset 1");
      step(4'h0, R0, 4'h0, 32'h0, 4'hF, 32'h0, 1'b0, "post reset 2");

      // Randomized traffic against the model.
      do_reset(4'h0);
      m_reset();
      cur = 4'h0;
      for (int n = 0; n < 800; n++) begin
         cur  = cur ^ (4'($urandom) & 4'($urandom));
         op   = $urandom_range(0, 9);
         rdce = 4'h0;
         wrce = 4'h0;
         data = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 15));
         be   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
         if (op >= 4 && op <= 6) rdce = 4'b1000 >> $urandom_range(0, 3);
         else if (op == 7 || op == 8) wrce = 4'b1000 >> $urandom_range(0, 3);
         else if (op == 9) begin
            rdce = 4'($urandom);
            wrce = 4'($urandom);
         end
         step(cur, rdce, wrce, data, be, m_read(rdce), m_irq, $sformatf("rand%0d", n));
         m_clock(cur, wrce, data, be);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
